// File: rtl/ssd_scan_decoder.sv
// Rebuilds the 16-bit hex value from a scanned 4-digit SSD bus; optional Dp capture under SSD_DP_CAPTURE_EN.
// Capture lands 2 + SETTLE_CYCLES + 1 cycles after a bus change; no backpressure, observe-only.
module ssd_scan_decoder #(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic        board_clk,
  input  logic        Reset,
  input  logic [3:0]  An,
  input  logic [7:0]  Cath,
  output logic [15:0] Digits,
  output logic [3:0]  DigitValid,
  output logic        Frame_Pulse,
  output logic        Bad_Pattern,
  output logic [3:0]  Dp_Out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

`ifdef SSD_DP_CAPTURE_EN
  localparam logic [7:0] CATH_MASK = 8'hFF;
`else
  // Dp bit is masked so a Dp-only change never looks like a new pattern
  localparam logic [7:0] CATH_MASK = 8'hFE;
`endif

  function automatic logic is_legal(input logic [3:0] a);
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] slot_of(input logic [3:0] a);
    case (a)
      4'b1110: slot_of = 2'd0;
      4'b1101: slot_of = 2'd1;
      4'b1011: slot_of = 2'd2;
      default: slot_of = 2'd3;
    endcase
  endfunction

  // Inverse of the hex-to-7seg table; bit 4 flags a hit
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = {1'b1, 4'h0};
      7'b1001111: decode = {1'b1, 4'h1};
      7'b0010010: decode = {1'b1, 4'h2};
      7'b0000110: decode = {1'b1, 4'h3};
      7'b1001100: decode = {1'b1, 4'h4};
      7'b0100100: decode = {1'b1, 4'h5};
      7'b0100000: decode = {1'b1, 4'h6};
      7'b0001111: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0000100: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b1100000: decode = {1'b1, 4'hB};
      7'b0110001: decode = {1'b1, 4'hC};
      7'b1000010: decode = {1'b1, 4'hD};
      7'b0110000: decode = {1'b1, 4'hE};
      7'b0111000: decode = {1'b1, 4'hF};
      default:    decode = {1'b0, 4'h0};
    endcase
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       an_meta;
  logic [3:0]       an_sync;
  logic [7:0]       cath_meta;
  logic [7:0]       cath_sync;
  logic [3:0]       an_lat;
  logic [7:0]       cath_lat;
  logic [3:0]       mask;

  logic [7:0] cath_eff;
  logic       an_legal;
  logic       bus_same;
  logic [4:0] dec;
  logic [1:0] slot;
  logic [3:0] mask_next;

  assign cath_eff  = cath_sync & CATH_MASK;
  assign an_legal  = is_legal(an_sync);
  assign bus_same  = (an_sync == an_lat) && (cath_eff == cath_lat);
  assign dec       = decode(cath_lat[7:1]);
  assign slot      = slot_of(an_lat);
  assign mask_next = mask | (4'b0001 << slot);

`ifdef SSD_DP_CAPTURE_EN
  logic [3:0] dp_q;
  assign Dp_Out = dp_q;
`else
  assign Dp_Out = 4'b0000;
`endif

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      an_meta     <= 4'b0000;
      an_sync     <= 4'b0000;
      cath_meta   <= 8'h00;
      cath_sync   <= 8'h00;
      an_lat      <= 4'b0000;
      cath_lat    <= 8'h00;
      mask        <= 4'b0000;
      Digits      <= 16'h0000;
      DigitValid  <= 4'b0000;
      Frame_Pulse <= 1'b0;
      Bad_Pattern <= 1'b0;
`ifdef SSD_DP_CAPTURE_EN
      dp_q        <= 4'b0000;
`endif
    end else begin
      an_meta     <= An;
      an_sync     <= an_meta;
      cath_meta   <= Cath;
      cath_sync   <= cath_meta;
      Frame_Pulse <= 1'b0;
      Bad_Pattern <= 1'b0;

      case (state)
        IDLE: begin
          if (an_legal) begin
            state    <= SETTLE;
            cnt      <= '0;
            an_lat   <= an_sync;
            cath_lat <= cath_eff;
          end
        end

        SETTLE: begin
          if (!an_legal) begin
            state <= IDLE;
          end else if (!bus_same) begin
            cnt      <= '0;
            an_lat   <= an_sync;
            cath_lat <= cath_eff;
          end else if (cnt == LAST_CNT) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CAPTURE: begin
          if (!an_legal) begin
            state <= IDLE;
          end else begin
            state <= HOLD;
            if (dec[4]) begin
              Digits[slot*4 +: 4] <= dec[3:0];
              DigitValid[slot]    <= 1'b1;
              // A completed frame clears the mask in the same cycle it fills
              if (mask_next == 4'b1111) begin
                Frame_Pulse <= 1'b1;
                mask        <= 4'b0000;
              end else begin
                mask <= mask_next;
              end
            end else begin
              Bad_Pattern      <= 1'b1;
              DigitValid[slot] <= 1'b0;
            end
`ifdef SSD_DP_CAPTURE_EN
            dp_q[slot] <= ~cath_lat[0];
`endif
          end
        end

        HOLD: begin
          if (!an_legal) begin
            state <= IDLE;
          end else if (an_sync != an_lat) begin
            state    <= SETTLE;
            cnt      <= '0;
            an_lat   <= an_sync;
            cath_lat <= cath_eff;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Run-level scoreboard bench for ssd_scan_decoder: each bus run is scored by stable length and slot rules.
module tb_ssd_scan_decoder;

  localparam int SETTLE = 16;
  localparam int NEED   = SETTLE + 1;

  logic        board_clk = 1'b0;
  logic        Reset;
  logic [3:0]  An;
  logic [7:0]  Cath;
  logic [15:0] Digits;
  logic [3:0]  DigitValid;
  logic        Frame_Pulse;
  logic        Bad_Pattern;
  logic [3:0]  Dp_Out;

  always #5 board_clk = ~board_clk;

  ssd_scan_decoder #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .board_clk  (board_clk),
    .Reset      (Reset),
    .An         (An),
    .Cath       (Cath),
    .Digits     (Digits),
    .DigitValid (DigitValid),
    .Frame_Pulse(Frame_Pulse),
    .Bad_Pattern(Bad_Pattern),
    .Dp_Out     (Dp_Out)
  );

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int tests = 0;
  int fails = 0;
  int frame_seen = 0;
  int bad_seen = 0;

  always @(negedge board_clk) begin
    if (Frame_Pulse === 1'b1) frame_seen++;
    if (Bad_Pattern === 1'b1) bad_seen++;
  end

  // Reference model state
  logic [15:0] m_digits;
  logic [3:0]  m_valid;
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  int          m_frames;
  int          m_bads;
  bit          slot_vld;
  logic [3:0]  slot_an;
  bit          slot_done;
  bit          key_vld;
  logic [11:0] prev_key;
  int          cur_len;

  function automatic logic [7:0] pat(input int d, input bit dp_lit);
    return {seg_tab[d], ~dp_lit};
  endfunction

  function automatic bit legal(input logic [3:0] a);
    return $countones(~a) == 1;
  endfunction

  function automatic logic [7:0] eff(input logic [7:0] c);
`ifdef SSD_DP_CAPTURE_EN
    return c;
`else
    return {c[7:1], 1'b0};
`endif
  endfunction

  task automatic model_reset();
    m_digits = '0; m_valid = '0; m_dp = '0; m_mask = '0;
    slot_vld = 0; slot_done = 0; key_vld = 0; cur_len = 0; slot_an = '0; prev_key = '0;
  endtask

  task automatic model_capture(input logic [3:0] an, input logic [7:0] c);
    int i;
    bit hit;
    int val;
    i = 0; hit = 0; val = 0;
    for (int b = 0; b < 4; b++) if (!an[b]) i = b;
    for (int k = 0; k < 16; k++) if (seg_tab[k] == c[7:1]) begin hit = 1; val = k; end
    if (hit) begin
      m_digits[i*4 +: 4] = 4'(val);
      m_valid[i] = 1'b1;
      m_mask[i]  = 1'b1;
      if (m_mask == 4'hF) begin
        m_frames++;
        m_mask = 4'h0;
      end
    end else begin
      m_bads++;
      m_valid[i] = 1'b0;
    end
`ifdef SSD_DP_CAPTURE_EN
    m_dp[i] = ~c[0];
`endif
  endtask

  // One run = bus held constant for len cycles
  task automatic model_run(input logic [3:0] an, input logic [7:0] c, input int len);
    logic [11:0] key;
    if (!legal(an)) begin
      slot_vld = 0; key_vld = 0; cur_len = 0;
      return;
    end
    key = {an, eff(c)};
    if (key_vld && key == prev_key) cur_len += len;
    else cur_len = len;
    prev_key = key; key_vld = 1;
    if (!slot_vld || an != slot_an) begin
      slot_vld = 1; slot_an = an; slot_done = 0;
    end
    if (!slot_done && cur_len >= NEED) begin
      slot_done = 1;
      model_capture(an, c);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".digits"}, 32'(Digits), 32'(m_digits));
    check({tag, ".valid"},  32'(DigitValid), 32'(m_valid));
    check({tag, ".dp"},     32'(Dp_Out), 32'(m_dp));
    check({tag, ".frames"}, 32'(frame_seen), 32'(m_frames));
    check({tag, ".bads"},   32'(bad_seen), 32'(m_bads));
  endtask

  task automatic run(input logic [3:0] an, input logic [7:0] c, input int len, input string tag);
    An = an;
    Cath = c;
    repeat (len) @(posedge board_clk);
    #1;
    model_run(an, c, len);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #1;
    check({tag, ".rst_digits"}, 32'(Digits), 32'h0);
    check({tag, ".rst_valid"},  32'(DigitValid), 32'h0);
    check({tag, ".rst_dp"},     32'(Dp_Out), 32'h0);
    check({tag, ".rst_frame"},  32'(Frame_Pulse), 32'h0);
    check({tag, ".rst_bad"},    32'(Bad_Pattern), 32'h0);
    model_reset();
    repeat (3) @(posedge board_clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    logic [3:0] ran;
    logic [7:0] rc;
    int rlen;

    An = 4'hF;
    Cath = 8'hFF;
    Reset = 1'b1;
    model_reset();
    m_frames = 0;
    m_bads = 0;
    repeat (3) @(posedge board_clk);
    #1;
    check_all("reset");
    Reset = 1'b0;

    // Three clean scans of 1,2,3,4
    for (int s = 0; s < 3; s++) begin
      run(4'b0111, pat(1, 0), 40, "scan_d3");
      run(4'b1011, pat(2, 0), 40, "scan_d2");
      run(4'b1101, pat(3, 0), 40, "scan_d1");
      run(4'b1110, pat(4, 0), 40, "scan_d0");
    end

    // Dp lit on An2 only
    run(4'b0111, pat(1, 0), 40, "dp_d3");
    run(4'b1011, pat(2, 1), 40, "dp_d2");
    run(4'b1101, pat(3, 0), 40, "dp_d1");
    run(4'b1110, pat(4, 0), 40, "dp_d0");

    // Cathode toggling faster than the settle window
    run(4'b1111, 8'hFF, 10, "pre_toggle");
    for (int t = 0; t < 6; t++) run(4'b1101, pat((t % 2) ? 8 : 7, 0), 8, "toggle");

    // Unknown pattern on An1
    run(4'b1101, {7'b1111110, 1'b1}, 40, "bad_pat");

    // Illegal anodes hold everything
    run(4'b0011, pat(5, 0), 100, "illegal_0011");
    run(4'b1111, pat(6, 0), 100, "illegal_1111");

    // Dp-only toggling: restarts settle only when Dp is captured
    for (int t = 0; t < 5; t++) run(4'b1110, pat(5, t % 2), 8, "dp_toggle");

    // ABCD, then reset in the middle of settling
    run(4'b0111, pat(10, 0), 40, "abcd_d3");
    run(4'b1011, pat(11, 0), 40, "abcd_d2");
    run(4'b1101, pat(12, 0), 40, "abcd_d1");
    run(4'b1110, pat(13, 0), 40, "abcd_d0");
    run(4'b0111, pat(14, 0), 10, "mid_settle");
    do_reset("mid_reset");
    run(4'b1110, pat(14, 0), 40, "after_reset");

    // Randomized runs
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        do ran = 4'($urandom); while (legal(ran));
      end else begin
        ran = ~(4'b0001 << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) < 8) rc = {seg_tab[$urandom_range(0, 15)], 1'($urandom)};
      else rc = 8'($urandom);
      if (legal(ran) && key_vld && {ran, eff(rc)} == prev_key) rc[7] = ~rc[7];
      rlen = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 8) : $urandom_range(30, 50);
      run(ran, rc, rlen, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
